// File: rtl/turn_cmd_gen.sv
// Driver pushbutton front end for the tail-light sequencer: synchronise, debounce and
// edge-detect the buttons, then run the LEFT/RIGHT/HAZARD mode FSM with brake overlay.
//
// state  | meaning
// IDLE   | no turn request, l=r=0
// LEFT   | left signal active until toggled, switched or timed out
// RIGHT  | right signal active until toggled, switched or timed out
// HAZARD | both lamps blink together; l/r presses ignored
module turn_cmd_gen #(
    parameter int DEB_CYCLES    = 16,
    parameter int TICK_DIV      = 1000000,
    parameter int TIMEOUT_TICKS = 20,
    parameter int BLINK_TICKS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_hz,
    input  logic       btn_brk,
    output logic       l,
    output logic       r,
    output logic       halt,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] TO_END    = OW'(TIMEOUT_TICKS);
    localparam logic [BW-1:0] BL_END    = BW'(BLINK_TICKS);

    // bit order everywhere: 0 = left, 1 = right, 2 = hazard, 3 = brake
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];
    logic [3:0]    press;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [OW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    mode_t         mode_q, mode_d;
    logic          l_q, l_d, r_q, r_d, halt_q, halt_d;

    assign raw = {btn_brk, btn_hz, btn_r, btn_l};

    // press is the rising edge of the debounced value, seen in the same cycle it flips
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
        press = deb_d & ~deb_q;
    end

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    always_comb begin
        mode_d      = mode_q;
        to_cnt_d    = to_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (press[2]) begin
            if (mode_q == HAZARD) begin
                mode_d = IDLE;
            end else begin
                mode_d      = HAZARD;
                phase_d     = 1'b1;
                blink_cnt_d = '0;
            end
        end else if ((press[0] ^ press[1]) && (mode_q != HAZARD)) begin
            to_cnt_d = '0;
            if (press[0]) begin
                mode_d = (mode_q == LEFT) ? IDLE : LEFT;
            end else begin
                mode_d = (mode_q == RIGHT) ? IDLE : RIGHT;
            end
        end else if (tick) begin
            case (mode_q)
                LEFT, RIGHT: begin
                    if (to_cnt_q != TO_END) begin
                        to_cnt_d = to_cnt_q + OW'(1);
                    end
                    if (to_cnt_d == TO_END) begin
                        mode_d = IDLE;
                    end
                end
                HAZARD: begin
                    if (blink_cnt_q + BW'(1) == BL_END) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        l_d    = (mode_q == LEFT)  || ((mode_q == HAZARD) && phase_q);
        r_d    = (mode_q == RIGHT) || ((mode_q == HAZARD) && phase_q);
        halt_d = deb_q[3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            tick_cnt_q  <= '0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode_q      <= IDLE;
            l_q         <= 1'b0;
            r_q         <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            tick_cnt_q  <= tick_cnt_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            l_q         <= l_d;
            r_q         <= r_d;
            halt_q      <= halt_d;
        end
    end

    assign l    = l_q;
    assign r    = r_q;
    assign halt = halt_q;
    assign mode = mode_q;

endmodule
